// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: NOP encoding, default reset PC,
// fetch FSM states and the skid-buffer entry layout.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer parking a fetched word while decode is stalled.
// Priority: clear > load > drain.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         drain,
  input  logic         clear,
  input  fetch_entry_t data_in,
  output fetch_entry_t data_out,
  output logic         full
);

  fetch_entry_t entry_q, entry_d;
  logic         full_q, full_d;

  always_comb begin
    entry_d = entry_q;
    full_d  = full_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      entry_d = data_in;
      full_d  = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
      full_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      full_q  <= full_d;
    end
  end

  assign data_out = entry_q;
  assign full     = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer and flush.
// Optional bubble counter enabled by defining FETCH_BUBBLE_CNT_EN.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instruction,
  output logic        valid
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic         valid_q, valid_d;

  logic         buf_load, buf_drain, buf_clear, buf_valid;
  fetch_entry_t buf_in, buf_out;
  logic         done;
  logic [1:0]   unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];
  assign done   = req_q & imem_ready;
  assign buf_in = '{pc: pc_q, instr: imem_rdata};

  fetch_skid_buf u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (buf_load),
    .drain    (buf_drain),
    .clear    (buf_clear),
    .data_in  (buf_in),
    .data_out (buf_out),
    .full     (buf_valid)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    valid_d     = valid_q;
    buf_load    = 1'b0;
    buf_drain   = 1'b0;
    buf_clear   = 1'b0;

    if (flush) begin
      // Any word completing this cycle is dropped; pc_q jumps to the target.
      valid_d     = 1'b0;
      out_instr_d = NOP_INSTR;
      buf_clear   = 1'b1;
      pc_d        = {redirect_pc[31:2], 2'b00};
      state_d     = ST_REQ;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (done) begin
            pc_d = pc_q + PC_STEP;
            if (stall) begin
              buf_load = 1'b1;
              state_d  = ST_HOLD;
            end else begin
              out_pc_d    = pc_q;
              out_instr_d = imem_rdata;
              valid_d     = 1'b1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            out_pc_d    = buf_out.pc;
            out_instr_d = buf_out.instr;
            valid_d     = buf_valid;
            buf_drain   = 1'b1;
            state_d     = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end

    // Request is a flop so stall/flush never reach imem_req combinationally.
    req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      req_q       <= 1'b1;
      out_pc_q    <= 32'h0;
      out_instr_q <= NOP_INSTR;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign PC          = out_pc_q;
  assign instruction = out_instr_q;
  assign valid       = valid_q;

`ifdef FETCH_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!valid_q && !stall && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= 32'h0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
